// File: rtl/word_tx_serializer.sv
// Word-to-byte return path: buffers result words in a small FIFO and streams
// each one to the UART transmitter over a valid/ready byte handshake.
//
// state | meaning
// IDLE  | no word in flight, tx_valid low; loads FIFO head when available
// SEND  | presenting current byte of the shift register, tx_valid high
module word_tx_serializer #(
    parameter int WIDTH_WORD = 128,
    parameter int NUM_BYTES  = WIDTH_WORD / 8,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH_DROP = 8
) (
    input  logic                  clk_slow,
    input  logic                  rst,
    input  logic [WIDTH_WORD-1:0] word_in,
    input  logic                  word_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic [WIDTH_DROP-1:0] drop_count,
    input  logic                  clear_overflow
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WIDTH_WORD-1:0]   shift_q, shift_d;
    logic [WIDTH_WORD-1:0]   shift_next;
    logic [WIDTH_WORD-1:0]   mem_q [FIFO_DEPTH];
    logic [WIDTH_WORD-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [WIDTH_DROP-1:0]   drop_q, drop_d;

    logic handshake;
    logic last_byte;
    logic fifo_nonempty;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_nonempty = (count_q != '0);
    assign handshake     = (state_q == SEND) && tx_ready;
    assign last_byte     = (idx_q == IDX_LAST);

    // The FSM is the only consumer; a pop frees a slot for a same-cycle push.
    assign pop  = fifo_nonempty &&
                  ((state_q == IDLE) || (handshake && last_byte));
    assign push = word_valid && ((count_q != CNT_FULL) || pop);
    assign drop = word_valid && !push;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = word_in;
        end
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_next = shift_q << 8;
        end else begin
            shift_next = shift_q >> 8;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (!last_byte) begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_next;
                    end else if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        idx_d   = '0;
                    end else begin
                        shift_d = shift_next;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_d != '1) begin
                drop_d = drop_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_slow) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign tx_data = shift_q[WIDTH_WORD-1 -: 8];
        end else begin : g_lsb
            assign tx_data = shift_q[7:0];
        end
    endgenerate

    assign tx_valid   = (state_q == SEND);
    assign busy       = (state_q == SEND) || fifo_nonempty;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_word_tx_serializer.sv
// Directed bench for word_tx_serializer: MSB-first instance with default
// parameters plus an LSB-first instance.
module tb_word_tx_serializer;

    localparam int W = 128;
    localparam logic [W-1:0] W_CNT = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [W-1:0] W_LSB = 128'h0F0E0D0C0B0A09080706050403020100;

    logic         clk_slow = 1'b0;
    logic         rst;
    logic [W-1:0] word_in;
    logic         word_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         overflow;
    logic [7:0]   drop_count;
    logic         clear_overflow;

    logic [W-1:0] word_in2;
    logic         word_valid2;
    logic [7:0]   tx_data2;
    logic         tx_valid2;
    logic         tx_ready2;
    logic         busy2;
    logic         overflow2;
    logic [7:0]   drop_count2;
    logic         clear_overflow2;

    int errors = 0;
    int checks = 0;

    always #5 clk_slow = ~clk_slow;

    word_tx_serializer dut (
        .clk_slow(clk_slow), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .overflow(overflow), .drop_count(drop_count), .clear_overflow(clear_overflow)
    );

    word_tx_serializer #(.MSB_FIRST(0)) dut_lsb (
        .clk_slow(clk_slow), .rst(rst), .word_in(word_in2), .word_valid(word_valid2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2),
        .overflow(overflow2), .drop_count(drop_count2), .clear_overflow(clear_overflow2)
    );

    task automatic step();
        @(posedge clk_slow);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        checks++; if (tx_valid2 !== 1'b0) begin errors++; $display("FAIL reset_lsb_tx_valid: got %b want 0", tx_valid2); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        word_in = W_CNT; word_valid = 1'b1; tx_ready = 1'b1;
        step();
        word_valid = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_cycle1_valid: got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_cycle1_busy: got %b want 1", busy); end
        step();
        for (int i = 0; i < 16; i++) begin
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", i, tx_valid); end
            checks++; if (tx_data !== 8'(i)) begin errors++; $display("FAIL single_byte[%0d]: got %h want %h", i, tx_data, 8'(i)); end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        word_in = W_CNT; word_valid = 1'b1; tx_ready = 1'b0;
        step();
        word_valid = 1'b0;
        for (int c = 0; c < 200 && n < 16; c++) begin
            tx_ready = (c % 3 == 1);
            if (tx_valid === 1'b1) begin
                // Covers both hold-while-stalled and no skip/repeat.
                checks++; if (tx_data !== 8'(n)) begin errors++; $display("FAIL bp_byte[%0d] cyc %0d: got %h want %h", n, c, tx_data, 8'(n)); end
                if (tx_ready) n++;
            end
            step();
        end
        tx_ready = 1'b1;
        checks++; if (n !== 16) begin errors++; $display("FAIL bp_count: got %0d want 16", n); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        tx_ready = 1'b1;
        word_in = {16{8'h11}}; word_valid = 1'b1;
        step();
        word_in = {16{8'h22}};
        step();
        word_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp = (i < 16) ? 8'h11 : 8'h22;
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, tx_valid); end
            checks++; if (tx_data !== exp) begin errors++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, tx_data, exp); end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", tx_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic [7:0] exp;
        tx_ready = 1'b0;
        word_in = {16{8'h44}}; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h44) begin errors++; $display("FAIL ovf_inflight: got valid=%b data=%h want valid=1 data=44", tx_valid, tx_data); end
        // In-flight word occupies the shift register; FIFO takes 2, the rest drop.
        for (int k = 0; k < 4; k++) begin
            b = 8'h55 + 8'(k * 17);
            word_in = {16{b}}; word_valid = 1'b1;
            step();
        end
        word_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drop_count: got %0d want 2", drop_count); end
        checks++; if (tx_data !== 8'h44) begin errors++; $display("FAIL ovf_held: got %h want 44", tx_data); end
        tx_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            exp = (i < 16) ? 8'h44 : ((i < 32) ? 8'h55 : 8'h66);
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp) begin errors++; $display("FAIL ovf_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp); end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_end_valid: got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_end_busy: got %b want 0", busy); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_flag: got %b want 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL clear_drop_count: got %0d want 0", drop_count); end
    endtask

    task automatic test_saturation();
        tx_ready = 1'b0;
        word_in = {16{8'hA5}}; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        word_valid = 1'b1;
        repeat (2) step();
        repeat (255) step();
        checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_reach: got %0d want 255", drop_count); end
        repeat (5) step();
        word_valid = 1'b0;
        checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %0d want 255", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", overflow); end
    endtask

    task automatic test_clear_drop();
        // FIFO still full from the saturation scenario, tx_ready still low.
        word_valid = 1'b1; clear_overflow = 1'b1;
        step();
        word_valid = 1'b0; clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clrdrop_flag: got %b want 1", overflow); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL clrdrop_count: got %0d want 1", drop_count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL clrdrop_rst: got ovf=%b cnt=%0d want ovf=0 cnt=0", overflow, drop_count); end
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clrdrop_rst_idle: got valid=%b busy=%b want 0 0", tx_valid, busy); end
    endtask

    task automatic test_reset_midframe();
        tx_ready = 1'b1;
        word_in = W_CNT; word_valid = 1'b1;
        step();
        word_in = {16{8'h33}};
        step();
        word_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin errors++; $display("FAIL rstmid_pre[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, 8'(i)); end
            step();
        end
        rst = 1'b1; tx_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        step();
        rst = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tx_ready = 1'b1;
        repeat (3) step();
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_discard: got valid=%b busy=%b want 0 0", tx_valid, busy); end
        word_in = W_CNT; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin errors++; $display("FAIL rstmid_new[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, 8'(i)); end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_end_valid: got %b want 0", tx_valid); end
    endtask

    task automatic test_lsb_first();
        word_in2 = W_LSB; word_valid2 = 1'b1; tx_ready2 = 1'b1;
        step();
        word_valid2 = 1'b0;
        checks++; if (tx_valid2 !== 1'b0) begin errors++; $display("FAIL lsb_cycle1_valid: got %b want 0", tx_valid2); end
        step();
        for (int i = 0; i < 16; i++) begin
            checks++; if (tx_valid2 !== 1'b1 || tx_data2 !== 8'(i)) begin errors++; $display("FAIL lsb_byte[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid2, tx_data2, 8'(i)); end
            step();
        end
        checks++; if (tx_valid2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL lsb_end: got valid=%b busy=%b want 0 0", tx_valid2, busy2); end
    endtask

    initial begin
        rst = 1'b1;
        word_in = '0; word_valid = 1'b0; tx_ready = 1'b0; clear_overflow = 1'b0;
        word_in2 = '0; word_valid2 = 1'b0; tx_ready2 = 1'b0; clear_overflow2 = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_saturation();
        test_clear_drop();
        test_reset_midframe();
        test_lsb_first();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
